// File: rtl/lpc_sniffer_pkg.sv
// lpc_sniffer_pkg: shared sync-header constants and frame-parser state encoding
package lpc_sniffer_pkg;
   localparam logic [7:0] SYNC_BYTE = 8'hFF;
   localparam int SYNC_LEN = 2;
   localparam int DEFAULT_FRAME_LEN = 7;
   typedef logic [2:0] state_t;
   localparam state_t HUNT_1  = 3'd0;
   localparam state_t HUNT_2  = 3'd1;
   localparam state_t PAYLOAD = 3'd2;
   localparam state_t COMMIT  = 3'd3;
   localparam state_t DROP    = 3'd4;
endpackage

// File: rtl/idle_timer.sv
// idle_timer: saturating 16-bit idle counter that flags the cycle it reaches LIMIT-1
//   clock, reset : system clock, synchronous active-high reset
//   enable       : count while high
//   clear        : zero the count (wins over enable)
//   expire       : high while enabled and the count sits at LIMIT-1
module idle_timer #(
   parameter logic [15:0] LIMIT = 16'd50000
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic expire
);
   logic [15:0] count;
   always_ff @(posedge clock) begin
      if (reset || clear) count <= '0;
      else if (enable && count != 16'hFFFF) count <= count + 16'd1;
   end
   assign expire = enable && count == LIMIT - 16'd1;
endmodule

// File: rtl/serial2mem.sv
// serial2mem: hunts for the FF FF sync header in a UART byte stream and writes each frame into a RAM slot
//   clock, reset   : system clock, synchronous active-high reset
//   uart_data/valid: received byte and its one-cycle strobe
//   write_full     : frame buffer full, sampled when the header completes
//   write_*        : registered RAM write port, address {slot, byte index}
//   slot           : index of the next frame to be committed
//   frame_done / frame_dropped / timeout_error : one-cycle status pulses
module serial2mem
   import lpc_sniffer_pkg::*;
#(
   parameter int AW = 8,
   parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [7:0]    uart_data,
   input  logic          uart_valid,
   input  logic          write_full,
   output logic          write_enable,
   output logic [AW-1:0] write_addr,
   output logic [7:0]    write_data,
   output logic [AW-4:0] slot,
   output logic          frame_done,
   output logic          frame_dropped,
   output logic          timeout_error
);
   state_t state;
   logic [2:0] lower_addr;
   logic expire;
   logic is_sync, last, timing;
   assign is_sync = uart_data == SYNC_BYTE;
   assign last = lower_addr == 3'(FRAME_LEN - 1);
   // the idle timer only guards a header or frame that has already started
   assign timing = state == HUNT_2 || state == PAYLOAD || state == DROP;

   idle_timer #(.LIMIT(TIMEOUT)) timer (
      .clock(clock),
      .reset(reset),
      .enable(timing),
      .clear(uart_valid || !timing),
      .expire(expire)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= HUNT_1;
         slot <= '0;
         lower_addr <= '0;
         write_enable <= 1'b0;
         write_addr <= '0;
         write_data <= '0;
         frame_done <= 1'b0;
         frame_dropped <= 1'b0;
         timeout_error <= 1'b0;
      end else begin
         write_enable <= 1'b0;
         frame_done <= 1'b0;
         frame_dropped <= 1'b0;
         timeout_error <= 1'b0;
         if (state == COMMIT) begin
            frame_done <= 1'b1;
            slot <= slot + 1'b1;
         end
         if (uart_valid) begin
            case (state)
               // a byte landing in the commit cycle is parsed as if already hunting
               HUNT_1, COMMIT: state <= is_sync ? HUNT_2 : HUNT_1;
               HUNT_2: begin
                  state <= !is_sync ? HUNT_1 : write_full ? DROP : PAYLOAD;
                  lower_addr <= '0;
               end
               PAYLOAD: begin
                  write_enable <= 1'b1;
                  write_addr <= {slot, lower_addr};
                  write_data <= uart_data;
                  lower_addr <= lower_addr + 3'd1;
                  if (last) state <= COMMIT;
               end
               DROP: begin
                  lower_addr <= lower_addr + 3'd1;
                  if (last) begin
                     frame_dropped <= 1'b1;
                     state <= HUNT_1;
                  end
               end
               default: state <= HUNT_1;
            endcase
         end else if (state == COMMIT) begin
            state <= HUNT_1;
         end else if (expire) begin
            timeout_error <= 1'b1;
            state <= HUNT_1;
         end
      end
   end
endmodule

// File: tb/tb_serial2mem.sv
// tb_serial2mem: directed and random byte streams against a byte-level frame parser model
module tb_serial2mem;
   localparam int AW = 4, FL = 7, TO = 40, NSLOT = 1 << (AW - 3);
   logic clock = 1'b0, reset = 1'b1, uart_valid = 1'b0, write_full = 1'b0;
   logic [7:0] uart_data = 8'h00;
   logic write_enable, frame_done, frame_dropped, timeout_error;
   logic [AW-1:0] write_addr;
   logic [7:0] write_data;
   logic [AW-4:0] slot;
   longint cyc = 0;
   logic [63:0] exp_q[$], act_q[$];
   int nvec = 0, nerr = 0;
   // model: phase 0 hunting, 1 one FF seen, 2 payload, 3 dropping
   int m_ph = 0, m_idx = 0, m_slot = 0;

   serial2mem #(.AW(AW), .FRAME_LEN(FL), .TIMEOUT(16'(TO))) dut (
      .clock(clock),
      .reset(reset),
      .uart_data(uart_data),
      .uart_valid(uart_valid),
      .write_full(write_full),
      .write_enable(write_enable),
      .write_addr(write_addr),
      .write_data(write_data),
      .slot(slot),
      .frame_done(frame_done),
      .frame_dropped(frame_dropped),
      .timeout_error(timeout_error)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // events are stamped with the cycle they are visible in: kind 1 write, 2 done, 3 dropped, 4 timeout
   function automatic logic [63:0] ev(longint c, int k, int a, int d);
      return {32'(c), 8'(k), 8'(a), 8'(d)};
   endfunction

   always @(negedge clock) begin
      if (write_enable) act_q.push_back(ev(cyc, 1, int'(write_addr), int'(write_data)));
      if (frame_done) act_q.push_back(ev(cyc, 2, 0, 0));
      if (frame_dropped) act_q.push_back(ev(cyc, 3, 0, 0));
      if (timeout_error) act_q.push_back(ev(cyc, 4, 0, 0));
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // drive one byte for a cycle, then idle so the next byte arrives gap cycles later
   task automatic put(input logic [7:0] b, input int gap);
      longint c;
      c = cyc;
      if (m_ph == 0) m_ph = b == 8'hFF ? 1 : 0;
      else if (m_ph == 1) begin
         m_ph = b != 8'hFF ? 0 : write_full ? 3 : 2;
         m_idx = 0;
      end else if (m_ph == 2) begin
         exp_q.push_back(ev(c + 1, 1, m_slot * 8 + m_idx, int'(b)));
         m_idx++;
         if (m_idx == FL) begin
            exp_q.push_back(ev(c + 2, 2, 0, 0));
            m_slot = (m_slot + 1) % NSLOT;
            m_ph = 0;
         end
      end else begin
         m_idx++;
         if (m_idx == FL) begin
            exp_q.push_back(ev(c + 1, 3, 0, 0));
            m_ph = 0;
         end
      end
      if (m_ph != 0 && gap > TO) begin
         exp_q.push_back(ev(c + TO + 1, 4, 0, 0));
         m_ph = 0;
      end
      uart_data = b;
      uart_valid = 1'b1;
      tick();
      uart_valid = 1'b0;
      repeat (gap - 1) tick();
   endtask

   task automatic send(input logic [127:0] s, input int n, input int gap, input int last_gap);
      for (int i = 0; i < n; i++) put(s[8*(n-1-i) +: 8], i == n - 1 ? last_gap : gap);
   endtask

   task automatic checkpoint(input string tag);
      logic [63:0] a, e;
      repeat (3) tick();
      while (exp_q.size() > 0 || act_q.size() > 0) begin
         e = exp_q.size() > 0 ? exp_q.pop_front() : '1;
         a = act_q.size() > 0 ? act_q.pop_front() : '1;
         chk({tag, "/event"}, a, e);
      end
      chk({tag, "/slot"}, 64'(slot), 64'(m_slot));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "/we"}, 64'(write_enable), 64'(0));
      chk({tag, "/addr"}, 64'(write_addr), 64'(0));
      chk({tag, "/data"}, 64'(write_data), 64'(0));
      chk({tag, "/slot"}, 64'(slot), 64'(0));
      chk({tag, "/done"}, 64'(frame_done), 64'(0));
      chk({tag, "/drop"}, 64'(frame_dropped), 64'(0));
      chk({tag, "/tmo"}, 64'(timeout_error), 64'(0));
   endtask

   initial begin
      int r, g;
      logic [7:0] b;
      repeat (3) tick();
      reset = 1'b0;
      chk_idle("reset");
      send({8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77}, 9, 10, 10);
      checkpoint("frame");
      send({8'hFF, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 11, 3, 5);
      checkpoint("ff_payload");
      send({8'hFF, 8'h01, 8'hFF, 8'h00}, 4, 3, 5);
      checkpoint("false_start");
      write_full = 1'b1;
      send({8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, 9, 2, 5);
      checkpoint("full_drop");
      write_full = 1'b0;
      send({8'hFF, 8'hFF, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27}, 9, 2, 5);
      checkpoint("after_drop");
      send({8'hFF, 8'hFF, 8'hAA, 8'hBB}, 4, 3, TO + 2);
      checkpoint("timeout");
      send({8'hFF, 8'hFF, 8'hAA}, 3, 2, TO);
      send({8'hBB, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5}, 6, 1, 5);
      checkpoint("expiry_byte");
      for (int f = 0; f < 3; f++)
         send({8'hFF, 8'hFF, 8'(f * 16 + 1), 8'(f * 16 + 2), 8'(f * 16 + 3), 8'(f * 16 + 4),
               8'(f * 16 + 5), 8'(f * 16 + 6), 8'(f * 16 + 7)}, 9, 1, f == 2 ? 5 : 1);
      checkpoint("wrap");
      send({8'hFF, 8'hFF, 8'hA1, 8'hA2, 8'hA3}, 5, 2, 2);
      checkpoint("pre_reset");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_ph = 0;
      m_slot = 0;
      chk_idle("mid_reset");
      send({8'hFF, 8'hFF, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7}, 9, 1, 5);
      checkpoint("post_reset");
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 19));
         b = r < 7 ? 8'hFF : 8'($urandom);
         g = r == 19 ? TO + int'($urandom_range(0, 1)) : int'($urandom_range(1, 3));
         if ($urandom_range(0, 15) == 0) write_full = ~write_full;
         put(b, g);
      end
      write_full = 1'b0;
      put(8'h5A, TO + 5);
      checkpoint("random");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
